// File: rtl/door_pkg.sv
// -----------------------------------------------------------------------------
// door_pkg
// Shared types and helpers for the shop-door motor controller.
//   door_state_e : FSM state encoding
//   pos_width()  : bits needed to hold a value in 0..n
//   cnt_width()  : bits needed to hold a value in 0..n-1 (minimum 1)
// -----------------------------------------------------------------------------
package door_pkg;

   typedef enum logic [2:0] {
      DOOR_CLOSED,
      DOOR_OPENING,
      DOOR_OPEN,
      DOOR_CLOSING,
      DOOR_FAULT
   } door_state_e;

   function automatic int unsigned pos_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/door_step_tick.sv
// -----------------------------------------------------------------------------
// door_step_tick
// Position-step prescaler. Counts 0..STEP_DIV-1 while enabled and flags the
// wrap cycle with a one-cycle tick.
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_clr   : clear counter (driven on every FSM state change)
//   i_en    : count enable (motor running)
//   o_tick  : high in the cycle the counter wraps
// -----------------------------------------------------------------------------
module door_step_tick
   import door_pkg::*;
#(
   parameter int unsigned STEP_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   localparam int unsigned CW = cnt_width(STEP_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/door_motor_ctrl.sv
// -----------------------------------------------------------------------------
// door_motor_ctrl
// Shop-door actuator stage: turns level open/close commands into motor drive,
// tracks door position in steps, reports limits and latches motor faults.
// Optional build macro: DOOR_OBSTRUCT_REOPEN_EN -- obstruction reopens a
// closing door and blocks OPEN -> CLOSING. Undefined: obstruct is ignored.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   openCmd    : level open request (wins over closeCmd)
//   closeCmd   : level close request
//   obstruct   : PIR presence in doorway
//   motorStall : motor energised but not moving; freezes position
//   motorUp    : drive motor in open direction (registered)
//   motorDown  : drive motor in close direction (registered)
//   doorMin    : position == 0 (registered)
//   doorMax    : position == TRAVEL (registered)
//   position   : current step count (registered)
//   fault      : latched in FAULT (registered)
// -----------------------------------------------------------------------------
module door_motor_ctrl
   import door_pkg::*;
#(
   parameter int unsigned TRAVEL   = 8,
   parameter int unsigned STEP_DIV = 4,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          openCmd,
   input  logic                          closeCmd,
   input  logic                          obstruct,
   input  logic                          motorStall,
   output logic                          motorUp,
   output logic                          motorDown,
   output logic                          doorMin,
   output logic                          doorMax,
   output logic [pos_width(TRAVEL)-1:0]  position,
   output logic                          fault
);

   localparam int unsigned PW = pos_width(TRAVEL);
   localparam int unsigned TW = pos_width(TIMEOUT);
   localparam logic [PW-1:0] POS_MAX = PW'(TRAVEL);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   door_state_e   r_state;
   door_state_e   w_state_d;
   logic [PW-1:0] r_pos;
   logic [PW-1:0] w_pos_d;
   logic [TW-1:0] r_tcnt;
   logic          w_tick;
   logic          w_step;
   logic          w_moving;
   logic          w_chg;
   logic          w_obs;

`ifdef DOOR_OBSTRUCT_REOPEN_EN
   assign w_obs = obstruct;
`else
   logic w_unused_obstruct;
   assign w_unused_obstruct = obstruct;
   assign w_obs = 1'b0;
`endif

   assign w_moving = (r_state == DOOR_OPENING) || (r_state == DOOR_CLOSING);
   assign w_chg    = (w_state_d != r_state);
   assign w_step   = w_tick && !motorStall;

   door_step_tick #(
      .STEP_DIV (STEP_DIV)
   ) u_step_tick (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_clr  (w_chg),
      .i_en   (w_moving),
      .o_tick (w_tick)
   );

   // Next state / next position. A reversal takes priority over a step in
   // the same cycle, and a limit arrival takes priority over the timeout.
   always_comb begin
      w_state_d = r_state;
      w_pos_d   = r_pos;
      case (r_state)
         DOOR_CLOSED: begin
            if (openCmd) w_state_d = DOOR_OPENING;
         end
         DOOR_OPEN: begin
            if (closeCmd && !openCmd && !w_obs) w_state_d = DOOR_CLOSING;
         end
         DOOR_OPENING: begin
            if (closeCmd && !openCmd) begin
               w_state_d = DOOR_CLOSING;
            end else begin
               if (w_step && (r_pos != POS_MAX)) w_pos_d = r_pos + 1'b1;
               if (w_step && (w_pos_d == POS_MAX)) begin
                  w_state_d = DOOR_OPEN;
               end else if (r_tcnt == TO_LAST) begin
                  w_state_d = DOOR_FAULT;
               end
            end
         end
         DOOR_CLOSING: begin
            if (openCmd || w_obs) begin
               w_state_d = DOOR_OPENING;
            end else begin
               if (w_step && (r_pos != '0)) w_pos_d = r_pos - 1'b1;
               if (w_step && (w_pos_d == '0)) begin
                  w_state_d = DOOR_CLOSED;
               end else if (r_tcnt == TO_LAST) begin
                  w_state_d = DOOR_FAULT;
               end
            end
         end
         default: begin
            // FAULT: sticky until reset, position held.
            w_state_d = DOOR_FAULT;
         end
      endcase
   end

   // State, position, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= DOOR_CLOSED;
         r_pos     <= '0;
         r_tcnt    <= '0;
         motorUp   <= 1'b0;
         motorDown <= 1'b0;
         doorMin   <= 1'b1;
         doorMax   <= 1'b0;
         fault     <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_pos     <= w_pos_d;
         r_tcnt    <= (w_chg || !w_moving) ? '0 : r_tcnt + 1'b1;
         motorUp   <= (w_state_d == DOOR_OPENING);
         motorDown <= (w_state_d == DOOR_CLOSING);
         doorMin   <= (w_pos_d == '0);
         doorMax   <= (w_pos_d == POS_MAX);
         fault     <= (w_state_d == DOOR_FAULT);
      end
   end

   assign position = r_pos;

endmodule

// File: doc/door_motor_ctrl.md
# door_motor_ctrl

Shop-door actuator stage that sits directly downstream of the shop controller. It consumes the controller's level open/close commands and drives the door motor up or down. It tracks door position with a step counter and produces the `doorMin`/`doorMax` limit signals that the controller consumes. It also detects motor stalls and, optionally, reverses a closing door when the PIR sensor reports an obstruction.

## Interface
Parameters:
- `TRAVEL`, 8: position steps from fully closed to fully open; must be ≥ 2.
- `STEP_DIV`, 4: clock cycles per position step while the motor runs; must be ≥ 1.
- `TIMEOUT`, 64: maximum cycles spent in one motion without reaching a limit.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `openCmd` input 1: level request to open; comes from `shopDoorOpen`.
- `closeCmd` input 1: level request to close; comes from `shopDoorClose`.
- `obstruct` input 1: PIR presence in the doorway.
- `motorStall` input 1: motor is energised but the door is not moving; position is frozen while this is high.
- `motorUp` output 1: drive the motor in the open direction.
- `motorDown` output 1: drive the motor in the close direction.
- `doorMin` output 1: position == 0.
- `doorMax` output 1: position == `TRAVEL`.
- `position` output `$clog2(TRAVEL+1)`: current step count.
- `fault` output 1: the module is latched in FAULT.

## Operation
- States are CLOSED, OPENING, OPEN, CLOSING and FAULT. All outputs are registered.
- Reset values: state CLOSED, `position`=0, `doorMin`=1, all other outputs 0, step and timeout counters 0. Reset overrides everything, including FAULT.
- CLOSED → OPENING when `openCmd`=1.
- OPEN → CLOSING when `closeCmd`=1 and `openCmd`=0.
- OPENING → CLOSING when `closeCmd`=1 and `openCmd`=0; this reversal takes effect on the next edge.
- CLOSING → OPENING when `openCmd`=1.
- Simultaneous `openCmd` and `closeCmd`: open always wins.
- Position stepping in OPENING or CLOSING: the step counter counts 0..`STEP_DIV`-1 and clears on every state change. When the counter wraps and `motorStall`=0, `position` moves by ±1.
- Limit arrival: the step that reaches `TRAVEL` moves the state to OPEN on the same edge; the step that reaches 0 moves it to CLOSED.
- Position saturates at 0 and `TRAVEL`; it never wraps.
- Timeout: the timeout counter counts cycles in OPENING/CLOSING and clears on every state change. When it reaches `TIMEOUT`, the state goes to FAULT. FAULT is sticky until `rst`; the motor is off and `position` is held there.
- `motorUp` = (state == OPENING) and `motorDown` = (state == CLOSING); the two are never high together.
- `doorMin` and `doorMax` are derived from the next-state position, so they change on the same edge as `position`.
- Commands in OPEN or CLOSED that would move the door towards the limit it already sits at are ignored.

## Timing
- A command sampled at edge k sets the new state and motor output after edge k.
- The first step lands at edge k+`STEP_DIV`.
- A full open from CLOSED takes `TRAVEL`×`STEP_DIV` cycles. `doorMax` rises and `motorUp` falls after edge k+`TRAVEL`×`STEP_DIV`.
- A reversal mid-travel keeps `position` and restarts the step count from 0.
- FAULT is entered after edge k+`TIMEOUT` when no limit has been reached.

## Configuration
- `DOOR_OBSTRUCT_REOPEN_EN` defined: in CLOSING, `obstruct`=1 forces OPENING on the next edge, even with `closeCmd` high. `obstruct` also blocks the OPEN → CLOSING transition.
- `DOOR_OBSTRUCT_REOPEN_EN` undefined: `obstruct` is ignored and no obstruction logic is synthesised.

## Structure
- Package `door_pkg` holds the state enum (`DOOR_CLOSED`, `DOOR_OPENING`, `DOOR_OPEN`, `DOOR_CLOSING`, `DOOR_FAULT`) and the position-width function.
- Sub-module `door_step_tick` holds the `STEP_DIV` prescaler. It has a clear input driven on state change and outputs a one-cycle `tick`.
- The top level holds the FSM, the position register and the timeout counter.

## Test plan
All scenarios use `TRAVEL`=8, `STEP_DIV`=4, `TIMEOUT`=64.
1. Assert `rst` for 2 cycles → `position`=0, `doorMin`=1, `doorMax`=0, `motorUp`=0, `motorDown`=0, `fault`=0.
2. Hold `openCmd` from edge 0 → `motorUp`=1 after edge 0; `position` steps 1..8 at edges 4, 8, …, 32; `doorMax`=1 and `motorUp`=0 after edge 32.
3. From OPEN, assert `closeCmd`; reassert `openCmd` at `position`=5 → `motorDown` drops and `motorUp` rises on the next edge; the next step (to 6) arrives 4 cycles later.
4. Hold `openCmd` and `motorStall` from CLOSED → `position` stays 0; `fault`=1 and both motor outputs are 0 after edge 64; `fault` clears only on `rst`.
5. Assert `openCmd` and `closeCmd` together from CLOSED → the state goes to OPENING and `motorUp`=1.
6. With `DOOR_OBSTRUCT_REOPEN_EN`, pulse `obstruct` during CLOSING at `position`=3 → OPENING on the next edge and `position` rises back to 8. Without the macro, the door continues to `position`=0 and `doorMin`=1.
